// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue stage: funct codes,
// ALU operation encodings and default datapath widths.
package alu_pkg;

  localparam int ALU_DATA_W  = 16;
  localparam int ALU_FUNCT_W = 4;

  localparam logic [3:0] FUNCT_AND  = 4'b0000;
  localparam logic [3:0] FUNCT_OR   = 4'b0001;
  localparam logic [3:0] FUNCT_ADD  = 4'b0010;
  localparam logic [3:0] FUNCT_SUB  = 4'b0110;
  localparam logic [3:0] FUNCT_SLT  = 4'b0111;
  localparam logic [3:0] FUNCT_NOR  = 4'b1100;
  localparam logic [3:0] FUNCT_NAND = 4'b1101;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational funct decoder: maps a function code onto the ripple ALU's
// invert/operation controls and flags undefined or purely logical codes.
module alu_funct_decode
  import alu_pkg::*;
#(
  parameter int FUNCT_W = ALU_FUNCT_W
) (
  input  logic [FUNCT_W-1:0] funct_i,
  output logic               invert_a_o,
  output logic               invert_b_o,
  output alu_op_e            operation_o,
  output logic               illegal_o,
  output logic               is_logic_o
);

  // Decode table; undefined codes fall back to a harmless AND with illegal set.
  always_comb begin
    invert_a_o  = 1'b0;
    invert_b_o  = 1'b0;
    operation_o = OP_AND;
    illegal_o   = 1'b0;
    is_logic_o  = 1'b0;
    case (funct_i)
      FUNCT_AND: begin
        is_logic_o = 1'b1;
      end
      FUNCT_OR: begin
        operation_o = OP_OR;
        is_logic_o  = 1'b1;
      end
      FUNCT_ADD: begin
        operation_o = OP_ADD;
      end
      FUNCT_SUB: begin
        invert_b_o  = 1'b1;
        operation_o = OP_ADD;
      end
      FUNCT_SLT: begin
        invert_b_o  = 1'b1;
        operation_o = OP_SLT;
      end
      FUNCT_NOR: begin
        invert_a_o = 1'b1;
        invert_b_o = 1'b1;
        is_logic_o = 1'b1;
      end
      FUNCT_NAND: begin
        invert_a_o  = 1'b1;
        invert_b_o  = 1'b1;
        operation_o = OP_OR;
        is_logic_o  = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready wrapper around an external 16-bit ripple ALU: stage 1
// holds and decodes the request, stage 2 captures the ALU outputs.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_W         = ALU_DATA_W,
  parameter int FUNCT_W        = ALU_FUNCT_W,
  parameter bit MASK_LOGIC_OVF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  output logic              alu_invertA,
  output logic              alu_invertB,
  output logic [1:0]        alu_operation,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_overflow,
  output logic              out_illegal,
  output logic [15:0]       done_count
);

  logic               s1_valid_q, s1_valid_d;
  logic [FUNCT_W-1:0] s1_funct_q, s1_funct_d;
  logic [DATA_W-1:0]  s1_src1_q,  s1_src1_d;
  logic [DATA_W-1:0]  s1_src2_q,  s1_src2_d;
  logic               s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0]  result_q,   result_d;
  logic               zero_q,     zero_d;
  logic               ovf_q,      ovf_d;
  logic               illegal_q,  illegal_d;
  logic [15:0]        done_q,     done_d;

  logic    s1_ready_s;
  logic    s2_ready_s;
  logic    dec_illegal_s;
  logic    dec_is_logic_s;
  alu_op_e dec_op_s;

  alu_funct_decode #(
    .FUNCT_W (FUNCT_W)
  ) u_decode (
    .funct_i     (s1_funct_q),
    .invert_a_o  (alu_invertA),
    .invert_b_o  (alu_invertB),
    .operation_o (dec_op_s),
    .illegal_o   (dec_illegal_s),
    .is_logic_o  (dec_is_logic_s)
  );

  assign s2_ready_s    = !s2_valid_q || out_ready;
  assign s1_ready_s    = !s1_valid_q || s2_ready_s;
  assign in_ready      = s1_ready_s;
  assign alu_src1      = s1_src1_q;
  assign alu_src2      = s1_src2_q;
  assign alu_operation = dec_op_s;

  // Next-state for both pipeline stages and the completion counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_funct_d = s1_funct_q;
    s1_src1_d  = s1_src1_q;
    s1_src2_d  = s1_src2_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    illegal_d  = illegal_q;
    done_d     = done_q;

    if (in_valid && s1_ready_s) begin
      s1_valid_d = 1'b1;
      s1_funct_d = in_funct;
      s1_src1_d  = in_src1;
      s1_src2_d  = in_src2;
    end else if (s2_ready_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    // Illegal requests report a clean zero result rather than ALU noise.
    if (s1_valid_q && s2_ready_s) begin
      s2_valid_d = 1'b1;
      if (dec_illegal_s) begin
        result_d  = {DATA_W{1'b0}};
        zero_d    = 1'b0;
        ovf_d     = 1'b0;
        illegal_d = 1'b1;
      end else begin
        result_d  = alu_result;
        zero_d    = alu_zero;
        ovf_d     = alu_overflow && !(MASK_LOGIC_OVF && dec_is_logic_s);
        illegal_d = 1'b0;
      end
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    if (s2_valid_q && out_ready) begin
      done_d = done_q + 16'd1;
    end else begin
      done_d = done_q;
    end
  end

  // State registers with synchronous reset that drops any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_funct_q <= {FUNCT_W{1'b0}};
      s1_src1_q  <= {DATA_W{1'b0}};
      s1_src2_q  <= {DATA_W{1'b0}};
      s2_valid_q <= 1'b0;
      result_q   <= {DATA_W{1'b0}};
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      illegal_q  <= 1'b0;
      done_q     <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_funct_q <= s1_funct_d;
      s1_src1_q  <= s1_src1_d;
      s1_src2_q  <= s1_src2_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      illegal_q  <= illegal_d;
      done_q     <= done_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_illegal  = illegal_q;
  assign done_count   = done_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage with a behavioural ripple ALU
// closing the loop between the alu_* outputs and inputs.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        o;
    logic        il;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_funct;
  logic [15:0] in_src1;
  logic [15:0] in_src2;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        alu_invertA;
  logic        alu_invertB;
  logic [1:0]  alu_operation;
  logic [15:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_illegal;
  logic [15:0] done_count;

  int   total = 0;
  int   bad = 0;
  int   exp_done = 0;
  bit   accepted;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_funct      (in_funct),
    .in_src1       (in_src1),
    .in_src2       (in_src2),
    .alu_src1      (alu_src1),
    .alu_src2      (alu_src2),
    .alu_invertA   (alu_invertA),
    .alu_invertB   (alu_invertB),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero),
    .alu_overflow  (alu_overflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_zero      (out_zero),
    .out_overflow  (out_overflow),
    .out_illegal   (out_illegal),
    .done_count    (done_count)
  );

  // Ripple ALU: conditional inversion, one adder with carry-in = invertB, SLT from adder sign.
  logic [15:0] m_a, m_b, m_sum;
  always_comb begin
    m_a          = alu_invertA ? ~alu_src1 : alu_src1;
    m_b          = alu_invertB ? ~alu_src2 : alu_src2;
    m_sum        = m_a + m_b + {15'd0, alu_invertB};
    alu_overflow = (m_a[15] == m_b[15]) && (m_sum[15] != m_a[15]);
    case (alu_operation)
      2'b00:   alu_result = m_a & m_b;
      2'b01:   alu_result = m_a | m_b;
      2'b10:   alu_result = m_sum;
      default: alu_result = {15'd0, m_sum[15]};
    endcase
    alu_zero = (alu_result == 16'd0);
  end

  function automatic exp_t model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] s;
    e = '0;
    case (f)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b1100: e.res = ~(a | b);
      4'b1101: e.res = ~(a & b);
      4'b0010: begin
        s     = a + b;
        e.res = s;
        e.o   = (a[15] == b[15]) && (s[15] != a[15]);
      end
      4'b0110, 4'b0111: begin
        s     = a - b;
        e.res = (f == 4'b0110) ? s : (($signed(a) < $signed(b)) ? 16'd1 : 16'd0);
        e.o   = (a[15] != b[15]) && (s[15] != a[15]);
      end
      default: e.il = 1'b1;
    endcase
    e.z = !e.il && (e.res == 16'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: evaluate handshakes before the edge, then step past it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (out_valid && sb.size() == 0) begin
        check("stale_out_valid", {31'd0, out_valid}, 32'd0);
      end else if (out_valid && out_ready) begin
        e = sb.pop_front();
        check("out_result", {16'd0, out_result}, {16'd0, e.res});
        check("out_zero", {31'd0, out_zero}, {31'd0, e.z});
        check("out_overflow", {31'd0, out_overflow}, {31'd0, e.o});
        check("out_illegal", {31'd0, out_illegal}, {31'd0, e.il});
        exp_done++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_funct, in_src1, in_src2));
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Offer one request and wait (bounded) until it is accepted; in_valid stays high.
  task automatic send(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, output int n);
    in_funct = f;
    in_src1  = a;
    in_src2  = b;
    in_valid = 1'b1;
    accepted = 1'b0;
    n        = 0;
    while (!accepted && n < 20) begin
      tick();
      n++;
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(output int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n         = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", sb.size(), 32'd0);
  endtask

  logic [3:0]  tp_f[5] = '{4'b0001, 4'b0010, 4'b1101, 4'b0010, 4'b0000};
  logic [15:0] tp_a[5] = '{16'h1200, 16'h7FFF, 16'hFFFF, 16'h1234, 16'h7FFF};
  logic [15:0] tp_b[5] = '{16'h0034, 16'h0001, 16'hFFFF, 16'h4321, 16'h7FFF};

  initial begin
    int          n;
    logic [15:0] hold_res;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_funct  = 4'd0;
    in_src1   = 16'd0;
    in_src2   = 16'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_done", {16'd0, done_count}, 32'd0);
    check("rst_result", {16'd0, out_result}, 32'd0);

    // SUB latency: not valid after the accept edge, valid after the next.
    out_ready = 1'b1;
    send(4'b0110, 16'h8000, 16'h0001, n);
    in_valid = 1'b0;
    check("sub_accept_ticks", n, 32'd1);
    check("sub_lat_k", {31'd0, out_valid}, 32'd0);
    tick();
    check("sub_lat_k1", {31'd0, out_valid}, 32'd1);
    check("sub_result", {16'd0, out_result}, 32'h7FFF);
    check("sub_ovf", {31'd0, out_overflow}, 32'd1);
    drain(n);

    send(4'b0111, 16'hFFFF, 16'h0001, n);
    send(4'b0111, 16'h0001, 16'hFFFF, n);
    send(4'b1100, 16'hFFFF, 16'h0000, n);
    send(4'b0000, 16'hF0F0, 16'h0FF0, n);
    drain(n);

    // Back-to-back stream: every request accepted on its first offer.
    for (int i = 0; i < 5; i++) begin
      send(tp_f[i], tp_a[i], tp_b[i], n);
      check("stream_accept_ticks", n, 32'd1);
    end
    drain(n);
    check("stream_tail_ticks", n, 32'd2);

    // Backpressure: third request stalls, outputs freeze, then drain in order.
    out_ready = 1'b0;
    send(4'b0010, 16'h0101, 16'h0202, n);
    send(4'b0110, 16'h0005, 16'h0007, n);
    check("bp_second_accept_ticks", n, 32'd1);
    in_funct = 4'b0001;
    in_src1  = 16'hA000;
    in_src2  = 16'h000A;
    accepted = 1'b0;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    hold_res = out_result;
    tick();
    tick();
    tick();
    check("bp_accepted", {31'd0, accepted}, 32'd0);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_result_stable", {16'd0, out_result}, {16'd0, hold_res});
    check("bp_result_first", {16'd0, out_result}, 32'h0303);
    out_ready = 1'b1;
    tick();
    check("bp_third_accepted", {31'd0, accepted}, 32'd1);
    drain(n);
    check("bp_drain_ticks", n, 32'd2);
    check("done_count", {16'd0, done_count}, exp_done);

    // Illegal code then a legal op clearing the flag.
    send(4'b1111, 16'h1234, 16'h5678, n);
    send(4'b0010, 16'h0001, 16'h0001, n);
    drain(n);

    // Reset with both stages full drops everything.
    out_ready = 1'b0;
    send(4'b0010, 16'h1111, 16'h2222, n);
    send(4'b0010, 16'h3333, 16'h4444, n);
    in_valid = 1'b0;
    check("full_out_valid", {31'd0, out_valid}, 32'd1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    exp_done = 0;
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_done", {16'd0, done_count}, 32'd0);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    check("rst2_no_stale", {31'd0, out_valid}, 32'd0);
    check("rst2_done_after", {16'd0, done_count}, exp_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
